uart_rx_fifo: RTL and testbench

Serial receive front end for the memory-mapped peripheral block. Deserialises the `rx` line (8N1, 16x oversampling) into bytes and buffers them in a small first-word-fall-through FIFO. Raises a level interrupt while data is pending. The peripheral register file pops bytes on CPU reads of the UART data address and reads its status flags.

---
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (16x oversampling) feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       full,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err,
  output logic       irq
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [TW-1:0] TMAX     = TW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state, state_n;

  logic          rx_m, rx_s, rx_d;
  logic          fall;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [3:0]    cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          start_smp, bit_smp, stop_smp, any_smp;
  logic          push_req, push, pop, ovr_set, ferr_set;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // rx_d trails rx_s by one cycle so a 1->0 transition can be seen
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge sys_clk) begin
    if (reset)
      tcnt <= '0;
    else if (state == S_IDLE && fall)
      tcnt <= '0;
    else if (tcnt == TMAX)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  assign tick = (tcnt == TMAX);

  always_ff @(posedge sys_clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

`ifdef UART_RX_PARITY_EN
  logic par_smp;
  logic par_bad;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (fall) state_n = S_START;
      S_START: if (start_smp) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_smp && bitcnt == 3'd7)
`ifdef UART_RX_PARITY_EN
          state_n = S_PAR;
`else
          state_n = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PAR:   if (par_smp) state_n = S_STOP;
`endif
      S_STOP:  if (stop_smp) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // start sample lands on the 8th tick, every later one on the 16th
  always_comb begin
    start_smp = (state == S_START) && tick && (cnt == 4'd7);
    bit_smp   = (state == S_DATA) && tick && (cnt == 4'd15);
    stop_smp  = (state == S_STOP) && tick && (cnt == 4'd15);
    any_smp   = start_smp | bit_smp | stop_smp;
`ifdef UART_RX_PARITY_EN
    par_smp   = (state == S_PAR) && tick && (cnt == 4'd15);
    any_smp   = any_smp | par_smp;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (reset || state == S_IDLE) begin
      cnt    <= '0;
      bitcnt <= '0;
    end else if (any_smp) begin
      cnt <= '0;
      if (bit_smp)
        bitcnt <= bitcnt + 1'b1;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset)
      shreg <= '0;
    else if (bit_smp)
      shreg <= {rx_s, shreg[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_smp)
        par_bad <= ^{rx_s, shreg};
      parity_err <= (parity_err & ~clr_err) | (par_smp & (^{rx_s, shreg}));
    end
  end

  assign push_req = stop_smp & rx_s & ~par_bad;
`else
  assign push_req   = stop_smp & rx_s;
  assign parity_err = 1'b0;
`endif

  assign ferr_set = stop_smp & ~rx_s;

  assign rx_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign irq      = rx_valid;
  assign rd_data  = mem[rd_ptr];

  // a pop in the same cycle frees the slot the push needs
  assign pop     = rd_en & rx_valid;
  assign push    = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun & ~clr_err) | ovr_set;
      frame_err <= (frame_err & ~clr_err) | ferr_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue model of the FIFO plus directed frames
// (DIV=1, DEPTH=4); outputs compared on every falling clock edge.
module tb_uart_rx_fifo;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       rx      = 1'b1;
  logic       rd_en   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, full, overrun, frame_err, parity_err, irq;

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000),
    .DEPTH   (4)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .full      (full),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .irq       (irq)
  );

  always #5 sys_clk = ~sys_clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  bit         chk_en = 1'b0;
  int         k       = 0;
  int         rst_cyc = 0;
  int         pop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
      check("irq", 32'(irq), 32'(q.size() != 0));
      check("full", 32'(full), 32'(q.size() == 4));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("parity_err", 32'(parity_err), 32'd0);
      if (q.size() != 0)
        check("rd_data", 32'(rd_data), 32'(q[0]));
    end
  end

  task automatic step();
    k++;
    if (k == rst_cyc) reset = 1'b1;
    if (k == pop_cyc) rd_en = 1'b1;
    @(posedge sys_clk);
    #1;
    reset   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // rcyc/pcyc: frame cycle (1-based) at which to pulse reset / rd_en
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int rcyc, input int pcyc);
    logic [9:0] bits;
    bits    = {stop_ok, b, 1'b0};
    chk_en  = 1'b0;
    k       = 0;
    rst_cyc = rcyc;
    pop_cyc = pcyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (16) step();
    end
    rx      = 1'b1;
    rst_cyc = 0;
    pop_cyc = 0;
    if (rcyc != 0) begin
      q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      if (pcyc != 0 && q.size() != 0)
        void'(q.pop_front());
      if (!stop_ok)
        m_ferr = 1'b1;
      else if (q.size() < 4)
        q.push_back(b);
      else
        m_ovr = 1'b1;
    end
    chk_en = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    if (q.size() != 0)
      void'(q.pop_front());
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    step();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    repeat (3) @(posedge sys_clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    idle(5);

    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 0, 0);
      begin
        while (!rx_valid && lat < 300) begin
          @(negedge sys_clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat - 1 < 153 || lat - 1 > 155) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 154+-1", lat - 1);
    end
    idle(4);
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_irq", 32'(irq), 32'd1);
    pop_check("a5_data", 8'hA5);
    check("a5_empty", 32'(rx_valid), 32'd0);

    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_ovr", 32'(overrun), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0, 0);
      if (i == 4) begin
        check("fill_full4", 32'(full), 32'd1);
        check("fill_ovr4", 32'(overrun), 32'd0);
      end
    end
    idle(3);
    check("fill_ovr5", 32'(overrun), 32'd1);
    pop_check("fill_pop1", 8'h01);
    pop_check("fill_pop2", 8'h02);
    pop_check("fill_pop3", 8'h03);
    pop_check("fill_pop4", 8'h04);
    check("fill_empty", 32'(rx_valid), 32'd0);
    clear_flags();
    check("fill_clr", 32'(overrun), 32'd0);
    idle(3);

    send_frame(8'h3C, 1'b0, 0, 0);
    idle(20);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_novalid", 32'(rx_valid), 32'd0);
    send_frame(8'h7E, 1'b1, 0, 0);
    idle(4);
    check("ferr_next_valid", 32'(rx_valid), 32'd1);
    pop_check("ferr_next_data", 8'h7E);
    clear_flags();
    check("ferr_clr", 32'(frame_err), 32'd0);
    idle(3);

    send_frame(8'h11, 1'b1, 0, 0);
    idle(2);
    send_frame(8'h22, 1'b1, 0, 0);
    idle(2);
    send_frame(8'h33, 1'b1, 0, 0);
    idle(2);
    send_frame(8'h44, 1'b1, 0, 0);
    idle(2);
    check("sim_full_pre", 32'(full), 32'd1);
    send_frame(8'h55, 1'b1, 0, 155);
    idle(4);
    check("sim_no_ovr", 32'(overrun), 32'd0);
    check("sim_full_post", 32'(full), 32'd1);
    pop_check("sim_pop1", 8'h22);
    pop_check("sim_pop2", 8'h33);
    pop_check("sim_pop3", 8'h44);
    pop_check("sim_pop4", 8'h55);
    check("sim_empty", 32'(rx_valid), 32'd0);
    idle(3);

    send_frame(8'hAA, 1'b1, 0, 0);
    idle(2);
    send_frame(8'hBB, 1'b1, 0, 0);
    idle(2);
    check("rstm_queued", 32'(rx_valid), 32'd1);
    send_frame(8'hF8, 1'b1, 72, 0);
    idle(4);
    check("rstm_empty", 32'(rx_valid), 32'd0);
    check("rstm_ovr", 32'(overrun), 32'd0);
    check("rstm_ferr", 32'(frame_err), 32'd0);
    send_frame(8'h99, 1'b1, 0, 0);
    idle(4);
    check("rstm_valid", 32'(rx_valid), 32'd1);
    pop_check("rstm_data", 8'h99);
    check("rstm_final_empty", 32'(rx_valid), 32'd0);
    idle(4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
